// File: rtl/reduce_pkg.sv
// Shared types and constants for the reduction checker and its transmit-side sibling.
package reduce_pkg;

  localparam int ERR_AND = 0;
  localparam int ERR_OR  = 1;
  localparam int ERR_XOR = 2;

  // Bit order matches the {xor,or,and} mismatch vector on the output stream.
  typedef struct packed {
    logic xor_e;
    logic or_e;
    logic and_e;
  } err_vec_t;

endpackage

// File: rtl/reduce_checker_if.sv
// Stream bundle between an upstream word source, the checker and the result sink.
interface reduce_checker_if #(
  parameter int W = 4
);
  // Valid/ready: a transfer happens on a rising edge where valid && ready; the
  // source holds valid and payload stable until then, and never waits on ready
  // before raising valid.
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         in_and;
  logic         in_or;
  logic         in_xor;
  logic         out_valid;
  logic         out_ready;
  logic [2:0]   out_err;
  logic [W-1:0] out_data;

  modport slave (
    input  in_valid, in_data, in_and, in_or, in_xor, out_ready,
    output in_ready, out_valid, out_err, out_data
  );

  modport master (
    output in_valid, in_data, in_and, in_or, in_xor, out_ready,
    input  in_ready, out_valid, out_err, out_data
  );
endinterface

// File: rtl/reduce_calc.sv
// Combinational AND/OR/XOR reduction of a W-bit word.
module reduce_calc #(
  parameter int W = 4
) (
  input  logic [W-1:0] data_i,
  output logic         red_and_o,
  output logic         red_or_o,
  output logic         red_xor_o
);

  assign red_and_o = &data_i;
  assign red_or_o  = |data_i;
  assign red_xor_o = ^data_i;

endmodule

// File: rtl/reduce_checker.sv
// Recomputes reductions of incoming words, flags wrong claimed bits through a
// one-entry output register, and keeps saturating word/error counters.
module reduce_checker
  import reduce_pkg::*;
#(
  parameter int W     = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  reduce_checker_if.slave  bus,
  input  logic             clear,
  output logic [CNT_W-1:0] word_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             err_sticky
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             calc_and, calc_or, calc_xor;
  logic [2:0]       err_bits;
  err_vec_t         err_new;
  logic             in_ready, in_fire, out_fire, any_err;

  logic             out_valid_q, out_valid_d;
  err_vec_t         out_err_q, out_err_d;
  logic [W-1:0]     out_data_q, out_data_d;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] word_base, err_base;

  reduce_calc #(.W(W)) u_calc (
    .data_i    (bus.in_data),
    .red_and_o (calc_and),
    .red_or_o  (calc_or),
    .red_xor_o (calc_xor)
  );

  always_comb begin
    err_bits          = '0;
    err_bits[ERR_AND] = calc_and != bus.in_and;
    err_bits[ERR_OR]  = calc_or  != bus.in_or;
    err_bits[ERR_XOR] = calc_xor != bus.in_xor;
  end

  assign err_new  = err_vec_t'(err_bits);
  assign any_err  = |err_bits;
  assign in_ready = !out_valid_q || bus.out_ready;
  assign in_fire  = bus.in_valid && in_ready;
  assign out_fire = out_valid_q && bus.out_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    out_err_d   = out_err_q;
    out_data_d  = out_data_q;
    if (in_fire) begin
      out_valid_d = 1'b1;
      out_err_d   = err_new;
      out_data_d  = bus.in_data;
    end else if (out_fire) begin
      out_valid_d = 1'b0;
    end
  end

  // clear zeroes the base first so a word accepted in the same cycle still counts.
  always_comb begin
    word_base  = clear ? '0 : word_cnt_q;
    err_base   = clear ? '0 : err_cnt_q;
    word_cnt_d = word_base;
    err_cnt_d  = err_base;
    sticky_d   = clear ? 1'b0 : sticky_q;
    if (in_fire) begin
      if (word_base != CNT_MAX) word_cnt_d = word_base + 1'b1;
      if (any_err) begin
        sticky_d = 1'b1;
        if (err_base != CNT_MAX) err_cnt_d = err_base + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_err_q   <= '0;
      out_data_q  <= '0;
      word_cnt_q  <= '0;
      err_cnt_q   <= '0;
      sticky_q    <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_err_q   <= out_err_d;
      out_data_q  <= out_data_d;
      word_cnt_q  <= word_cnt_d;
      err_cnt_q   <= err_cnt_d;
      sticky_q    <= sticky_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_err   = out_err_q;
  assign bus.out_data  = out_data_q;
  assign word_cnt      = word_cnt_q;
  assign err_cnt       = err_cnt_q;
  assign err_sticky    = sticky_q;

endmodule

// File: tb/tb_reduce_checker.sv
// Bench for reduce_checker: directed cases then random traffic, two counter widths.
module tb_reduce_checker;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst, clear;
  logic in_valid, in_and, in_or, in_xor, out_ready;
  logic [W-1:0] in_data;

  logic [7:0] word_cnt_a, err_cnt_a;
  logic       sticky_a;
  logic [1:0] word_cnt_b, err_cnt_b;
  logic       sticky_b;

  int checks   = 0;
  int failures = 0;

  logic [6:0] exp_q[$];
  logic [6:0] last_res = '0;
  int words_seen = 0;
  int errs_seen  = 0;

  reduce_checker_if #(.W(W)) if_a ();
  reduce_checker_if #(.W(W)) if_b ();

  assign if_a.in_valid  = in_valid;
  assign if_a.in_data   = in_data;
  assign if_a.in_and    = in_and;
  assign if_a.in_or     = in_or;
  assign if_a.in_xor    = in_xor;
  assign if_a.out_ready = out_ready;
  assign if_b.in_valid  = in_valid;
  assign if_b.in_data   = in_data;
  assign if_b.in_and    = in_and;
  assign if_b.in_or     = in_or;
  assign if_b.in_xor    = in_xor;
  assign if_b.out_ready = out_ready;

  reduce_checker #(.W(W), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .bus(if_a), .clear(clear),
    .word_cnt(word_cnt_a), .err_cnt(err_cnt_a), .err_sticky(sticky_a)
  );

  reduce_checker #(.W(W), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .bus(if_b), .clear(clear),
    .word_cnt(word_cnt_b), .err_cnt(err_cnt_b), .err_sticky(sticky_b)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] ref_err(input logic [W-1:0] d, input logic ca,
                                         input logic co, input logic cx);
    logic t_and, t_or, t_xor;
    t_and = (d == W'((1 << W) - 1));
    t_or  = (d != 0);
    t_xor = ($countones(d) % 2) == 1;
    return {t_xor != cx, t_or != co, t_and != ca};
  endfunction

  function automatic int sat(input int v, input int max);
    return (v > max) ? max : v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic v, input logic [W-1:0] d, input logic ca,
                       input logic co, input logic cx);
    in_valid = v;
    in_data  = d;
    in_and   = ca;
    in_or    = co;
    in_xor   = cx;
  endtask

  // One clock: check everything at the falling edge, then advance the model.
  task automatic cycle();
    logic fire_in, fire_out;
    logic [2:0] e;
    logic [6:0] cur;
    @(negedge clk);
    cur = (exp_q.size() != 0) ? exp_q[0] : last_res;
    chk("in_ready",   32'(if_a.in_ready),  32'((exp_q.size() == 0) || out_ready));
    chk("out_valid",  32'(if_a.out_valid), 32'(exp_q.size() != 0));
    chk("out_data",   32'(if_a.out_data),  32'(cur[3:0]));
    chk("out_err",    32'(if_a.out_err),   32'(cur[6:4]));
    chk("word_cnt_a", 32'(word_cnt_a),     32'(sat(words_seen, 255)));
    chk("err_cnt_a",  32'(err_cnt_a),      32'(sat(errs_seen, 255)));
    chk("sticky_a",   32'(sticky_a),       32'(errs_seen != 0));
    chk("word_cnt_b", 32'(word_cnt_b),     32'(sat(words_seen, 3)));
    chk("err_cnt_b",  32'(err_cnt_b),      32'(sat(errs_seen, 3)));
    chk("sticky_b",   32'(sticky_b),       32'(errs_seen != 0));
    fire_in  = in_valid && ((exp_q.size() == 0) || out_ready);
    fire_out = (exp_q.size() != 0) && out_ready;
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      last_res   = '0;
      words_seen = 0;
      errs_seen  = 0;
    end else begin
      if (fire_out) last_res = exp_q.pop_front();
      if (clear) begin
        words_seen = 0;
        errs_seen  = 0;
      end
      if (fire_in) begin
        e = ref_err(in_data, in_and, in_or, in_xor);
        exp_q.push_back({e, in_data});
        last_res = {e, in_data};
        words_seen++;
        if (e != 0) errs_seen++;
      end
    end
    #1;
  endtask

  initial begin
    logic [W-1:0] d;
    logic [2:0] flip;
    logic t_and, t_or, t_xor;
    rst = 1'b1;
    clear = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state, then correct words back-to-back.
    cycle();
    drive(1'b1, 4'hF, 1'b1, 1'b1, 1'b0); cycle();
    drive(1'b1, 4'h0, 1'b0, 1'b0, 1'b0); cycle();
    drive(1'b1, 4'h6, 1'b0, 1'b1, 1'b0); cycle();
    drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0); cycle();
    cycle();

    // Single-bit faults.
    drive(1'b1, 4'h7, 1'b1, 1'b1, 1'b1); cycle();
    drive(1'b1, 4'h7, 1'b0, 1'b1, 1'b0); cycle();
    drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0); cycle();

    // Backpressure: one word parked, next word held by upstream for 5 cycles.
    out_ready = 1'b0;
    drive(1'b1, 4'hA, 1'b0, 1'b1, 1'b0); cycle();
    drive(1'b1, 4'h3, 1'b1, 1'b1, 1'b0);
    repeat (5) cycle();
    out_ready = 1'b1; cycle();
    drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0); cycle();
    cycle();

    // Saturation on the narrow-counter instance.
    clear = 1'b1; cycle(); clear = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, W'(i + 2), 1'b1, 1'b0, 1'b1);
      cycle();
    end
    drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0); cycle();

    // clear colliding with an erroneous word.
    clear = 1'b1;
    drive(1'b1, 4'h1, 1'b1, 1'b1, 1'b1); cycle();
    clear = 1'b0;
    drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0); cycle();

    // Reset while a result is parked.
    out_ready = 1'b0;
    drive(1'b1, 4'hC, 1'b1, 1'b1, 1'b1); cycle();
    drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1; cycle();
    rst = 1'b0; cycle();
    out_ready = 1'b1; cycle();

    // Random traffic; an unaccepted word is held until it transfers.
    for (int i = 0; i < 300; i++) begin
      if (!(in_valid && !((exp_q.size() == 0) || out_ready))) begin
        d = W'($urandom_range(0, (1 << W) - 1));
        t_and = (d == W'((1 << W) - 1));
        t_or  = (d != 0);
        t_xor = ($countones(d) % 2) == 1;
        flip  = ($urandom_range(0, 1) == 1) ? 3'($urandom_range(0, 7)) : 3'b000;
        drive(1'($urandom_range(0, 3) != 0), d, t_and ^ flip[0], t_or ^ flip[1],
              t_xor ^ flip[2]);
      end
      out_ready = 1'($urandom_range(0, 3) != 0);
      clear     = 1'($urandom_range(0, 15) == 0);
      cycle();
    end
    clear = 1'b0;
    drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    out_ready = 1'b1;
    repeat (2) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reduce_checker.md
Name: reduce_checker

Overview:
- Receive-side counterpart of the 4-bit reduction gate block (AND/OR/XOR of a nibble).
- Accepts words together with their claimed reduction bits over a valid/ready stream, and recomputes the reductions.
- Reports a per-word mismatch vector downstream through a one-entry output register with backpressure.
- Keeps saturating word/error counters and a sticky error flag for status readout.

Parameters:
- W, 4, data width checked by the reductions (W >= 1)
- CNT_W, 8, width of the word and error counters

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  upstream word valid
- in_ready  output  1  block can accept a word this cycle
- in_data  input  W  data word
- in_and  input  1  claimed AND-reduction of in_data
- in_or  input  1  claimed OR-reduction of in_data
- in_xor  input  1  claimed XOR-reduction of in_data
- out_valid  output  1  check result valid
- out_ready  input  1  downstream accepts the result
- out_err  output  3  mismatch vector {xor,or,and}; bit set = claimed bit wrong
- out_data  output  W  data word the result belongs to
- clear  input  1  synchronous clear of counters and sticky flag
- word_cnt  output  CNT_W  words accepted, saturating
- err_cnt  output  CNT_W  words with any mismatch, saturating
- err_sticky  output  1  set on the first erroneous word; held until clear or rst

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-high, port rst.
- Reset values: out_valid=0, out_err=0, out_data=0, word_cnt=0, err_cnt=0, err_sticky=0. in_ready is combinational and equals 1 in the cycle after reset.
- Handshake: in_ready = !out_valid || out_ready (combinational). An input transfer occurs when in_valid && in_ready. An output transfer occurs when out_valid && out_ready.
- Latency: exactly 1 cycle. A word accepted at edge t has its result visible at out_valid/out_err/out_data from t+1.
- Throughput: 1 word/cycle while out_ready=1.
- Output register:
  - On input transfer: load out_data=in_data and out_err={^in_data != in_xor, |in_data != in_or, &in_data != in_and}; set out_valid=1.
  - On output transfer without an input transfer: out_valid=0. out_err and out_data hold their last values.
  - Output transfer and input transfer in the same cycle: load the new result and keep out_valid=1.
  - While out_valid=1 && out_ready=0: all outputs stable and in_ready=0.
- Counters and sticky flag (update on input transfer):
  - word_cnt += 1.
  - If the computed mismatch vector != 0: err_cnt += 1 and err_sticky = 1.
  - Both counters saturate at 2^CNT_W-1; there is no wrap.
- clear:
  - Zeroes word_cnt, err_cnt and err_sticky.
  - Does not touch the output register or the handshake.
  - clear with a simultaneous input transfer: clear wins, but the new word is still counted, i.e. word_cnt=1 and err_cnt/err_sticky reflect that word only.
- Reset mid-operation: rst drops any pending result (out_valid=0) and zeroes all state. rst has priority over clear and over transfers.
- W=1 case: all three reductions equal in_data; the checks stay independent.
- Inputs are not sampled when in_ready=0; the upstream must hold them per valid/ready rules.

Decomposition:
- Shared package reduce_pkg:
  - typedef err_vec_t (3-bit packed struct {xor_e, or_e, and_e}).
  - Bit-index constants ERR_AND=0, ERR_OR=1, ERR_XOR=2.
- One natural sub-module, reduce_calc: purely combinational W-bit AND/OR/XOR reduction. It is shared with the transmit-side gate block for reuse.
- Counters, sticky flag and output register stay in reduce_checker.

Test Plan:
- Correct words, back-to-back: send 4'hF/1,1,0, 4'h0/0,0,0, 4'h6/0,1,0 with out_ready=1 -> three results one cycle after each accept, out_err=0 each, word_cnt=3, err_cnt=0, err_sticky=0.
- Single-bit faults: 4'h7 claimed and=1,or=1,xor=1 -> out_err=3'b001. Then 4'h7 claimed 0,1,0 -> out_err=3'b100. Afterwards err_cnt=2, err_sticky=1.
- Backpressure: hold out_ready=0 after one accepted word -> in_ready=0, out_data/out_err stable for 5 cycles. Raise out_ready with in_valid=1 -> result and new word swap in the same cycle, out_valid stays 1.
- Saturation: CNT_W=2, send 6 erroneous words -> word_cnt=3 and err_cnt=3 stay at 3, no wrap.
- clear collision: assert clear in the same cycle as accepting erroneous word 4'h1 (claimed 1,1,1) -> next cycle word_cnt=1, err_cnt=1, err_sticky=1.
- Reset mid-stream: rst while out_valid=1 and out_ready=0 -> next cycle out_valid=0, counters 0, in_ready=1.
